// File: rtl/alu_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_arbiter                                              |
// | Description : Two-requester round-robin front end for a shared         |
// |               combinational ALU. Two-stage pipeline: S1 issue register |
// |               drives the ALU, S2 response register captures its        |
// |               result. Valid/ready handshakes on both sides.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Parameters  : XLEN - operand / result width                            |
// | Ports       : clk, rst_n (async, active-low)                           |
// |               reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b (N = 0,1)    |
// |               alu_op/alu_a/alu_b out, alu_result in (shared ALU)       |
// |               rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_err            |
// |               busy - either pipeline stage occupied                    |
// | Build macro : ALU_ARB_ILLEGAL_OP_CHECK_EN - when defined, op codes     |
// |               12..14 are flagged as errors: the ALU sees NOP and the   |
// |               response carries rsp_err=1, rsp_result=0.                |
// +------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_err,
  output logic            busy
);

  localparam logic [3:0] c_op_nop = 4'hF;

  // S1 issue register
  logic            r_s1_valid;
  logic [3:0]      r_s1_op;
  logic [XLEN-1:0] r_s1_a;
  logic [XLEN-1:0] r_s1_b;
  logic            r_s1_id;
  logic            r_s1_err;

  // S2 response register
  logic            r_s2_valid;
  logic            r_s2_id;
  logic [XLEN-1:0] r_s2_result;
  logic            r_s2_err;

  // Requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic            r_last_grant;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic [3:0]      w_in_op;
  logic [XLEN-1:0] w_in_a;
  logic [XLEN-1:0] w_in_b;
  logic            w_in_err;

  assign w_s2_adv = ~r_s2_valid | rsp_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;

  // Round-robin: a lone requester always wins; on a tie the one not granted last wins.
  assign w_gnt0   = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1   = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept = w_s1_adv & (w_gnt0 | w_gnt1);

  // The rst_n term only keeps ready low while reset is asserted; the state
  // itself is already cleared asynchronously.
  assign req0_ready = rst_n & w_s1_adv & w_gnt0;
  assign req1_ready = rst_n & w_s1_adv & w_gnt1;

  assign w_in_op = w_gnt1 ? req1_op : req0_op;
  assign w_in_a  = w_gnt1 ? req1_a  : req0_a;
  assign w_in_b  = w_gnt1 ? req1_b  : req0_b;

`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
  assign w_in_err = (w_in_op >= 4'd12) && (w_in_op <= 4'd14);
`else
  assign w_in_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= c_op_nop;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= 1'b0;
      r_s1_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op  <= w_in_op;
        r_s1_a   <= w_in_a;
        r_s1_b   <= w_in_b;
        r_s1_id  <= w_gnt1;
        r_s1_err <= w_in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_id     <= 1'b0;
      r_s2_result <= '0;
      r_s2_err    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id     <= r_s1_id;
        r_s2_err    <= r_s1_err;
        // Flagged ops never reach the ALU, so their result is forced to zero.
        r_s2_result <= r_s1_err ? '0 : alu_result;
      end
    end
  end

  // An empty or error-flagged S1 presents NOP to the ALU.
  assign alu_op = (r_s1_valid && !r_s1_err) ? r_s1_op : c_op_nop;
  assign alu_a  = r_s1_valid ? r_s1_a : '0;
  assign alu_b  = r_s1_valid ? r_s1_b : '0;

  assign rsp_valid  = r_s2_valid;
  assign rsp_id     = r_s2_id;
  assign rsp_result = r_s2_result;
  assign rsp_err    = r_s2_err;
  assign busy       = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                           |
// | Description : Scoreboard bench for alu_arbiter. A behavioural ALU      |
// |               answers the DUT's ALU port; a queue of accepted          |
// |               operations predicts grants, occupancy, latency and       |
// |               responses. Honours ALU_ARB_ILLEGAL_OP_CHECK_EN.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int XLEN = 32;
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
  localparam bit ILL_CHK = 1'b1;
`else
  localparam bit ILL_CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [3:0]      req0_op = 4'd0, req1_op = 4'd0;
  logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            rsp_valid, rsp_id, rsp_err;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_result;
  logic            busy;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; undefined codes return a distinctive non-zero pattern.
  function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd10:   return a;
      4'd11:   return b;
      default: return a ^ b ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

  function automatic bit is_illegal(input logic [3:0] op);
    return ILL_CHK && (op >= 4'd12) && (op <= 4'd14);
  endfunction

  typedef struct {
    logic            id;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            err;
    int              acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   last_pop = -100;
  bit   head_seen = 1'b0;
  bit   last_g = 1'b1;
  bit   acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every negedge compare DUT against the queue model, then retire/accept.
  always @(negedge clk) begin
    int   sz, s1_idx, vis;
    logic e0, e1, cap;
    exp_t e;
    if (!rst_n) begin
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else begin
      sz = q.size();
      chk("busy", busy, (sz != 0));
      // S2 holds q[0] when a response is showing, so S1 holds the next one.
      s1_idx = rsp_valid ? 1 : 0;
      if (s1_idx < sz) begin
        chk("alu_issue", {alu_op, alu_a, alu_b},
            {(q[s1_idx].err ? 4'hF : q[s1_idx].op), q[s1_idx].a, q[s1_idx].b});
      end else begin
        chk("alu_idle", {alu_op, alu_a, alu_b}, {4'hF, {(2*XLEN){1'b0}}});
      end

      cap = (sz < 2) || rsp_ready;
      e0  = cap && req0_valid && (!req1_valid || last_g);
      e1  = cap && req1_valid && (!req0_valid || !last_g);
      if (req0_valid || req1_valid || req0_ready || req1_ready)
        chk("grant", {req1_ready, req0_ready}, {e1, e0});
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;

      if (rsp_valid) begin
        if (sz == 0) begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          if (!head_seen) begin
            vis = (q[0].acc_cyc + 2 > last_pop + 1) ? q[0].acc_cyc + 2 : last_pop + 1;
            chk("rsp_latency", cyc, vis);
            head_seen = 1'b1;
          end
          chk("rsp_data", {rsp_id, rsp_err, rsp_result}, {q[0].id, q[0].err, q[0].res});
          if (rsp_ready) begin
            void'(q.pop_front());
            last_pop  = cyc;
            head_seen = 1'b0;
          end
        end
      end

      if (acc0 || acc1) begin
        e.id      = acc0 ? 1'b0 : 1'b1;
        e.op      = acc0 ? req0_op : req1_op;
        e.a       = acc0 ? req0_a  : req1_a;
        e.b       = acc0 ? req0_b  : req1_b;
        e.err     = is_illegal(e.op);
        e.res     = e.err ? '0 : alu_ref(e.op, e.a, e.b);
        e.acc_cyc = cyc;
        q.push_back(e);
        last_g = e.id;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    q.delete();
    last_pop = -100;
    head_seen = 1'b0;
    last_g = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic wait_acc0(input string nm);
    int n;
    n = 0;
    do begin step(); n++; end while (!acc0 && n < 10);
    chk(nm, acc0, 1'b1);
  endtask

  initial begin
    int k;
    logic [3:0]      bp_op[3];
    logic [XLEN-1:0] bp_a[3], bp_b[3];

    // Reset values, with both requesters asking so ready must still be low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_result}, '0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, {4'hF, {(2*XLEN){1'b0}}});
    do_reset();

    // Single ADD 5+7 from requester 0.
    rsp_ready = 1'b1;
    req0_op = 4'd0; req0_a = 5; req0_b = 7; req0_valid = 1'b1;
    wait_acc0("single_accept");
    req0_valid = 1'b0;
    chk("single_alu", {alu_op, alu_a, alu_b}, {4'd0, 32'd5, 32'd7});
    drain();

    // Tie after reset: SUB 10-3 vs XOR F0^0F, alternating grants, no bubbles.
    do_reset();
    req0_op = 4'd1; req0_a = 10;    req0_b = 3;
    req1_op = 4'd4; req1_a = 'hF0;  req1_b = 'h0F;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    repeat (8) step();
    drain();

    // Backpressure: three back-to-back requester-1 ops with rsp_ready low 4 cycles.
    bp_op[0] = 4'd0; bp_a[0] = 1;     bp_b[0] = 2;
    bp_op[1] = 4'd1; bp_a[1] = 9;     bp_b[1] = 4;
    bp_op[2] = 4'd3; bp_a[2] = 'h30;  bp_b[2] = 'h03;
    k = 0;
    rsp_ready = 1'b0;
    req1_op = bp_op[0]; req1_a = bp_a[0]; req1_b = bp_b[0]; req1_valid = 1'b1;
    for (int i = 0; i < 30 && k < 3; i++) begin
      step();
      if (i == 3) rsp_ready = 1'b1;
      if (acc1) begin
        k++;
        if (k < 3) begin
          req1_op = bp_op[k]; req1_a = bp_a[k]; req1_b = bp_b[k];
        end else begin
          req1_valid = 1'b0;
        end
      end
    end
    chk("bp_all_accepted", k, 3);
    drain();

    // Op 13 from requester 0.
    req0_op = 4'd13; req0_a = 3; req0_b = 5; req0_valid = 1'b1;
    wait_acc0("illegal_accept");
    req0_valid = 1'b0;
    chk("illegal_alu_op", alu_op, ILL_CHK ? 4'hF : 4'd13);
    drain();

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_op = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_op = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset while both stages are full.
    req0_op = 4'd2; req0_a = 'hFF; req0_b = 'h0F; req0_valid = 1'b1; rsp_ready = 1'b0;
    repeat (4) step();
    chk("mid_full", q.size(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp", {rsp_valid, busy, req1_ready, req0_ready}, 4'b0000);
    chk("mid_rst_alu", alu_op, 4'hF);
    do_reset();
    rsp_ready = 1'b1;
    repeat (5) step();

    // Idle for 10 cycles.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) step();
    chk("idle_end", {busy, alu_op, alu_a, alu_b}, {1'b0, 4'hF, {(2*XLEN){1'b0}}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand and result width.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester N accepted this cycle.
REQ-006 SHALL have ports: req0_op / req1_op  input  4  ALU op in alu_op_e encoding (ADD=0 … B_PASSTHROUGH=11, NOP=4'hF).
REQ-007 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  XLEN  operands.
REQ-008 SHALL have ports: alu_op  output  4; alu_a, alu_b  output  XLEN; drive the shared combinational ALU.
REQ-009 SHALL have port: alu_result  input  XLEN  combinational ALU output for current alu_op/alu_a/alu_b.
REQ-010 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (requester index); rsp_result  output  XLEN; rsp_err  output  1.
REQ-011 SHALL have port: busy  output  1  high when either pipeline stage holds an operation.

Function
REQ-012 SHALL implement two stages: S1 issue register (op, a, b, id, err) driving alu_*; S2 response register capturing alu_result.
REQ-013 S2 SHALL advance (become empty or reload) when rsp_valid=0 or rsp_ready=1; S1 SHALL advance when S1 empty or S2 advances.
REQ-014 A request SHALL be accepted only when S1 advances; reqN_ready=1 only for the granted requester in that cycle, never both.
REQ-015 Grant SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last_grant updates only on acceptance.
REQ-016 Latency SHALL be 2 cycles: accepted at edge N -> alu_* valid after N -> rsp_valid=1 after edge N+1.
REQ-017 With rsp_ready held high and continuous requests, throughput SHALL be one response per cycle, zero bubbles.
REQ-018 Under backpressure (rsp_valid=1, rsp_ready=0) rsp_* and alu_* SHALL hold stable, no new accept while S1 full.
REQ-019 When S1 empty, alu_op SHALL be 4'hF (NOP) and alu_a = alu_b = 0.
REQ-020 Responses SHALL return in acceptance order; rsp_id equals accepted requester index.
REQ-021 Requester ready MAY depend on the other requester's valid; requesters SHALL hold valid/op/operands until ready.
REQ-022 busy SHALL equal S1 valid OR S2 valid.

Reset
REQ-023 On rst_n low, immediately: S1 and S2 invalid, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, req*_ready=0, busy=0, alu_op=4'hF, alu_a=alu_b=0, last_grant=1 (requester 0 wins first tie).
REQ-024 Reset mid-operation SHALL discard in-flight operations with no response issued; first accept permitted on first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro ALU_ARB_ILLEGAL_OP_CHECK_EN defined: ops 12–14 SHALL be accepted normally, S1 carries err=1, alu_op driven 4'hF, response has rsp_err=1, rsp_result=0.
REQ-026 Macro undefined: all op codes forwarded unchanged to alu_op, rsp_result=alu_result, rsp_err tied 0.

Verification
REQ-027 Single request: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready pulse 1 cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_result=12.
REQ-028 Tie after reset: both valid every cycle, req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants 0,1,0,1; responses 7 (id 0), 0xFF (id 1) alternating, one per cycle.
REQ-029 Backpressure: 3 back-to-back req1 ops, rsp_ready=0 for 4 cycles -> 2 accepted, req1_ready low thereafter, rsp_* stable; release -> all 3 delivered in order.
REQ-030 Reset mid-flight: rst_n low while S1 and S2 full -> rsp_valid=0 and busy=0 same cycle, no stale response after release.
REQ-031 Illegal op 13 from req0: with ALU_ARB_ILLEGAL_OP_CHECK_EN -> rsp_err=1, rsp_result=0, alu_op=4'hF while in S1; without -> alu_op=13, rsp_err=0.
REQ-032 Idle: no valids for 10 cycles -> alu_op=4'hF, alu_a=alu_b=0, busy=0, no ready asserted.
